// File: rtl/reg_universal_n.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/inc/clear, plus a shift/rotate-by-N engine.
// Optional even-parity output `par` is enabled by defining REG_UNIVERSAL_N_PARITY_EN.
module reg_universal_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic [CNT_W-1:0] amt,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
`ifdef REG_UNIVERSAL_N_PARITY_EN
  ,
  output logic             par
`endif
);

  // Handshake: start is accepted only in IDLE or DONE and only for modes 010-101;
  // busy is high exactly while stepping (RUN), done pulses for one cycle (DONE).
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic             sout_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       lmode, lmode_n;
  logic             is_shift;

  // Returns {sout, q} after one step of operation m.
  function automatic logic [WIDTH:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             cur_sout,
    input logic             s_in,
    input logic [WIDTH-1:0] data
  );
    logic [WIDTH:0] r;
    case (m)
      3'b001:  r = {cur_sout, data};
      3'b010:  r = {cur[WIDTH-1], cur[WIDTH-2:0], s_in};
      3'b011:  r = {cur[0], s_in, cur[WIDTH-1:1]};
      3'b100:  r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  r = {cur[0], cur[0], cur[WIDTH-1:1]};
      3'b110:  r = {cur_sout, cur + Q_ONE};
      3'b111:  r = {cur_sout, {WIDTH{1'b0}}};
      default: r = {cur_sout, cur};
    endcase
    return r;
  endfunction

  assign is_shift = (mode >= 3'b010) && (mode <= 3'b101);

  always_comb begin
    state_n = state;
    q_n     = q;
    sout_n  = sout;
    cnt_n   = cnt;
    lmode_n = lmode;
    case (state)
      RUN: begin
        {sout_n, q_n} = step_fn(lmode, q, sout, sin, d);
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_n = DONE;
      end
      default: begin
        state_n = IDLE;
        if (start && is_shift) begin
          if (amt != '0) begin
            lmode_n = mode;
            cnt_n   = amt;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end else if (en) begin
          {sout_n, q_n} = step_fn(mode, q, sout, sin, d);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      sout  <= 1'b0;
      cnt   <= '0;
      lmode <= 3'b000;
    end else begin
      state <= state_n;
      q     <= q_n;
      sout  <= sout_n;
      cnt   <= cnt_n;
      lmode <= lmode_n;
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

`ifdef REG_UNIVERSAL_N_PARITY_EN
  assign par = ^q;
`endif

endmodule

// File: tb/tb_reg_universal_n.sv
// Directed bench for reg_universal_n: a per-cycle vector table plus hand-written handshake sequences.
module tb_reg_universal_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [3:0] amt;
  logic       start;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;
`ifdef REG_UNIVERSAL_N_PARITY_EN
  logic       par;
`endif

  int checks = 0;
  int errors = 0;

  reg_universal_n #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .amt(amt), .start(start), .q(q), .sout(sout), .busy(busy),
    .done(done), .fsm_state(fsm_state)
`ifdef REG_UNIVERSAL_N_PARITY_EN
    , .par(par)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [3:0] amt;
    logic       start;
    logic [7:0] eq;
    logic       es;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                     input logic s, input logic [3:0] a, input logic st,
                     input logic [7:0] eq, input logic es, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sin = s; v.amt = a; v.start = st;
    v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic drive(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic s, input logic [3:0] a, input logic st);
    @(negedge clk);
    rst = r; en = e; mode = m; d = dd; sin = s; amt = a; start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
    chk8({tag, ".q"}, q, eq);
    chk1({tag, ".sout"}, sout, es);
    chk1({tag, ".busy"}, busy, eb);
    chk1({tag, ".done"}, done, ed);
  endtask

  initial begin
    int cycles;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0; amt = 4'd0; start = 1'b0;

    //   rst   en    mode    d      sin   amt   start   q      sout  busy  done
    add(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0, 1'b0,   8'h00, 1'b0, 1'b0, 1'b0); // reset
    add(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 4'd0, 1'b0,   8'hA5, 1'b0, 1'b0, 1'b0); // load
    add(1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 4'd0, 1'b0,   8'h81, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 4'd0, 1'b0,   8'h02, 1'b1, 1'b0, 1'b0); // shl sin=0
    add(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 4'd0, 1'b0,   8'h01, 1'b0, 1'b0, 1'b0); // rotr
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 4'd0, 1'b0,   8'h80, 1'b1, 1'b0, 1'b0); // shr sin=1
    add(1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 4'd0, 1'b0,   8'hFF, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 4'd0, 1'b0,   8'h00, 1'b1, 1'b0, 1'b0); // inc wraps
    add(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0, 1'b0,   8'h00, 1'b1, 1'b0, 1'b0); // hold
    add(1'b0, 1'b0, 3'b001, 8'h55, 1'b0, 4'd0, 1'b0,   8'h00, 1'b1, 1'b0, 1'b0); // en=0
    add(1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 4'd0, 1'b0,   8'h3C, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 4'd0, 1'b0,   8'h00, 1'b1, 1'b0, 1'b0); // clear
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 4'd0, 1'b0,   8'h01, 1'b0, 1'b0, 1'b0); // shl sin=1
    add(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 4'd0, 1'b0,   8'h02, 1'b0, 1'b0, 1'b0); // rotl
    add(1'b0, 1'b1, 3'b001, 8'h96, 1'b0, 4'd0, 1'b0,   8'h96, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 4'd3, 1'b1,   8'h96, 1'b0, 1'b1, 1'b0); // start rotl x3
    add(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 4'hF, 1'b1,   8'h2D, 1'b1, 1'b1, 1'b0); // junk ignored
    add(1'b0, 1'b1, 3'b111, 8'hFF, 1'b1, 4'h1, 1'b0,   8'h5A, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h11, 1'b1, 4'h2, 1'b1,   8'hB4, 1'b0, 1'b0, 1'b1); // done pulse
    add(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0, 1'b0,   8'hB4, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].mode, vq[i].d, vq[i].sin, vq[i].amt, vq[i].start);
      chk_state($sformatf("vec%0d", i), vq[i].eq, vq[i].es, vq[i].eb, vq[i].ed);
    end

    // amt=0: done next cycle, q unchanged, busy never rises
    drive(1'b0, 1'b0, 3'b010, 8'h00, 1'b1, 4'd0, 1'b1);
    chk_state("amt0", 8'hB4, 1'b0, 1'b0, 1'b1);
    idle();
    chk_state("amt0_after", 8'hB4, 1'b0, 1'b0, 1'b0);

    // start with a non-shift mode is a plain load
    drive(1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 4'd5, 1'b1);
    chk_state("start_load", 8'h3C, 1'b0, 1'b0, 1'b0);
    idle();
    chk_state("start_load_after", 8'h3C, 1'b0, 1'b0, 1'b0);

    // shr x2 with sin=1, then back-to-back rotr x1 launched in the DONE cycle
    drive(1'b0, 1'b0, 3'b011, 8'h00, 1'b1, 4'd2, 1'b1);
    chk_state("b2b_e0", 8'h3C, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 4'd0, 1'b0);
    chk_state("b2b_e1", 8'h9E, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 4'd0, 1'b0);
    chk_state("b2b_e2", 8'hCF, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 3'b101, 8'h00, 1'b0, 4'd1, 1'b1);
    chk_state("b2b_next", 8'hCF, 1'b0, 1'b1, 1'b0);
    idle();
    chk_state("b2b_done", 8'hE7, 1'b1, 1'b0, 1'b1);

    // maximum count: shl x15 with sin=0, done must arrive 15 edges after start
    drive(1'b0, 1'b0, 3'b010, 8'h00, 1'b0, 4'd15, 1'b1);
    chk1("max_busy0", busy, 1'b1);
    cycles = 0;
    while (!done && cycles < 40) begin
      idle();
      cycles++;
      if (busy && done) chk1("busy_and_done", 1'b1, 1'b0);
    end
    chk8("max_cycles", 8'(cycles), 8'd15);
    chk_state("max_end", 8'h00, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a run
    drive(1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 3'b100, 8'h00, 1'b0, 4'd5, 1'b1);
    idle();
    chk_state("pre_rst", 8'h03, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0, 1'b0);
    chk_state("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef REG_UNIVERSAL_N_PARITY_EN
    chk1("par_rst", par, 1'b0);
`endif
    idle();
    chk_state("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 4'd0, 1'b0);
    chk_state("post_rst_load", 8'hA5, 1'b0, 1'b0, 1'b0);

`ifdef REG_UNIVERSAL_N_PARITY_EN
    drive(1'b0, 1'b1, 3'b001, 8'h07, 1'b0, 4'd0, 1'b0);
    chk1("par_07", par, 1'b1);
    drive(1'b0, 1'b1, 3'b001, 8'h03, 1'b0, 4'd0, 1'b0);
    chk1("par_03", par, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
